cc_level_manager: RTL and testbench

- Sequential level tracker for the Frogger game core, generalising the fixed "level == 5" comparator.
- Holds the current level, accepts one advance per frog-reaches-goal event, and flags the last level and the win condition.
- Final level, counter width and win-hold time are parameters.
- Sits between the goal-detect logic and the speed/display selectors.

---
 rtl/cc_level_manager.sv | 99 +++++++++
 tb/tb_cc_level_manager.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cc_level_manager.sv
// Frogger level tracker: counts goal events up to MAX_LEVEL, then flags the win.
// Optional macro CC_LEVEL_MANAGER_AUTORESTART_EN restarts play after WIN_HOLD_CYCLES in WIN.
module cc_level_manager #(
  parameter int LEVEL_WIDTH     = 5,
  parameter int MAX_LEVEL       = 5,
  parameter int WIN_HOLD_CYCLES = 50000000,
  parameter int HOLD_WIDTH      = 26
) (
  input  logic                   CC_LEVEL_MANAGER_CLOCK_50,
  input  logic                   CC_LEVEL_MANAGER_RESET_InHigh,
  input  logic                   CC_LEVEL_MANAGER_clear_InLow,
  input  logic                   CC_LEVEL_MANAGER_advance_InLow,
  output logic [LEVEL_WIDTH-1:0] CC_LEVEL_MANAGER_level_Out,
  output logic                   CC_LEVEL_MANAGER_levelup_OutHigh,
  output logic                   CC_LEVEL_MANAGER_last_OutLow,
  output logic                   CC_LEVEL_MANAGER_win_OutLow
);

  typedef enum logic {PLAY = 1'b0, WIN = 1'b1} state_t;

  localparam logic [LEVEL_WIDTH-1:0] MaxLevel = LEVEL_WIDTH'(MAX_LEVEL);

  state_t                 state, nextState;
  logic [LEVEL_WIDTH-1:0] level, nextLevel;
  logic                   levelup, nextLevelup;
  logic                   advQ;
  logic                   advEvent;

`ifdef CC_LEVEL_MANAGER_AUTORESTART_EN
  localparam logic [HOLD_WIDTH-1:0] HoldLast = HOLD_WIDTH'(WIN_HOLD_CYCLES - 1);
  logic [HOLD_WIDTH-1:0] holdCnt, nextHold;
`endif

  // falling edge of the active-low goal input, one event per assertion
  assign advEvent = advQ & ~CC_LEVEL_MANAGER_advance_InLow;

  always_ff @(posedge CC_LEVEL_MANAGER_CLOCK_50 or posedge CC_LEVEL_MANAGER_RESET_InHigh) begin
    if (CC_LEVEL_MANAGER_RESET_InHigh) begin
      state   <= PLAY;
      level   <= '0;
      levelup <= 1'b0;
      advQ    <= 1'b1;
`ifdef CC_LEVEL_MANAGER_AUTORESTART_EN
      holdCnt <= '0;
`endif
    end else begin
      state   <= nextState;
      level   <= nextLevel;
      levelup <= nextLevelup;
      advQ    <= CC_LEVEL_MANAGER_advance_InLow;
`ifdef CC_LEVEL_MANAGER_AUTORESTART_EN
      holdCnt <= nextHold;
`endif
    end
  end

  always_comb begin
    nextState   = state;
    nextLevel   = level;
    nextLevelup = 1'b0;
`ifdef CC_LEVEL_MANAGER_AUTORESTART_EN
    nextHold    = '0;
`endif
    // clear wins over a coincident advance; that event is simply dropped
    if (!CC_LEVEL_MANAGER_clear_InLow) begin
      nextState = PLAY;
      nextLevel = '0;
    end else begin
      case (state)
        PLAY: begin
          if (advEvent) begin
            nextLevelup = 1'b1;
            if (level == MaxLevel) nextState = WIN;
            else                   nextLevel = level + LEVEL_WIDTH'(1);
          end
        end
        WIN: begin
`ifdef CC_LEVEL_MANAGER_AUTORESTART_EN
          if (holdCnt == HoldLast) begin
            nextState = PLAY;
            nextLevel = '0;
          end else begin
            nextHold = holdCnt + HOLD_WIDTH'(1);
          end
`endif
        end
        default: nextState = PLAY;
      endcase
    end
  end

  always_comb begin
    CC_LEVEL_MANAGER_level_Out       = level;
    CC_LEVEL_MANAGER_levelup_OutHigh = levelup;
    CC_LEVEL_MANAGER_last_OutLow     = (level != MaxLevel);
    CC_LEVEL_MANAGER_win_OutLow      = (state != WIN);
  end

endmodule

// File: tb/tb_cc_level_manager.sv
// Scoreboard bench for cc_level_manager: each expected levelup pulse is queued by the
// stimulus and checked by an independent monitor; steady-state values are checked inline.
module tb_cc_level_manager;

  localparam int LW = 5;
  localparam int MAXL = 5;
`ifdef CC_LEVEL_MANAGER_AUTORESTART_EN
  localparam int HOLD = 8;
  localparam int HW = 4;
`else
  localparam int HOLD = 50000000;
  localparam int HW = 26;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clearN = 1'b1;
  logic          advN = 1'b1;
  logic [LW-1:0] level;
  logic          levelup, lastN, winN;

  typedef struct {
    int lvl;
    int last;
    int win;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nPass = 0;
  logic prevUp = 1'b0;

  cc_level_manager #(
    .LEVEL_WIDTH(LW), .MAX_LEVEL(MAXL), .WIN_HOLD_CYCLES(HOLD), .HOLD_WIDTH(HW)
  ) dut (
    .CC_LEVEL_MANAGER_CLOCK_50       (clk),
    .CC_LEVEL_MANAGER_RESET_InHigh   (rst),
    .CC_LEVEL_MANAGER_clear_InLow    (clearN),
    .CC_LEVEL_MANAGER_advance_InLow  (advN),
    .CC_LEVEL_MANAGER_level_Out      (level),
    .CC_LEVEL_MANAGER_levelup_OutHigh(levelup),
    .CC_LEVEL_MANAGER_last_OutLow    (lastN),
    .CC_LEVEL_MANAGER_win_OutLow     (winN)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectPulse(input int lvl, input int last, input int win);
    exp_t e;
    e.lvl = lvl; e.last = last; e.win = win;
    expQ.push_back(e);
  endtask

  // advance low 3 cycles, high 3 cycles
  task automatic pulseAdvance();
    advN = 1'b0;
    tick(3);
    advN = 1'b1;
    tick(3);
  endtask

  // monitor: every levelup pulse must match the head of the queue and be one cycle wide
  always @(negedge clk) begin
    exp_t e;
    if (levelup === 1'b1) begin
      nChecks++;
      if (expQ.size() == 0) begin
        $display("FAIL unexpected levelup: level %0d, no pulse expected (t=%0t)", level, $time);
      end else begin
        nPass++;
        e = expQ.pop_front();
        check("pulse level", int'(level), e.lvl);
        check("pulse last_OutLow", int'(lastN), e.last);
        check("pulse win_OutLow", int'(winN), e.win);
      end
      check("pulse width (prev cycle levelup)", int'(prevUp), 0);
    end
    prevUp = levelup;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(2);
    check("reset level", int'(level), 0);
    check("reset levelup", int'(levelup), 0);
    check("reset last_OutLow", int'(lastN), 1);
    check("reset win_OutLow", int'(winN), 1);
    rst = 1'b0;
    tick(2);

    // climb to the final level
    for (int i = 1; i <= MAXL; i++) begin
      expectPulse(i, (i == MAXL) ? 0 : 1, 1);
      pulseAdvance();
      check("climb level", int'(level), i);
    end
    check("at max last_OutLow", int'(lastN), 0);
    check("at max win_OutLow", int'(winN), 1);

    // one more advance enters WIN
    expectPulse(MAXL, 0, 0);
    advN = 1'b0;
    tick(1);
    advN = 1'b1;
    tick(1);
    check("win entered win_OutLow", int'(winN), 0);
    check("win level holds", int'(level), MAXL);

    // advance in WIN is ignored (monitor flags any pulse)
    advN = 1'b0;
    tick(1);
    advN = 1'b1;
    tick(1);
    check("win ignore level", int'(level), MAXL);
    check("win ignore win_OutLow", int'(winN), 0);

    n = 0;
    while (winN == 1'b0 && n < 1100) begin
      tick(1);
      n++;
    end
`ifdef CC_LEVEL_MANAGER_AUTORESTART_EN
    check("autorestart win low cycles", 3 + n, HOLD);
    check("autorestart level", int'(level), 0);
    check("autorestart last_OutLow", int'(lastN), 1);
`else
    check("win held after 1100 cycles", int'(winN), 0);
    check("win held level", int'(level), MAXL);
`endif

    clearN = 1'b0;
    tick(1);
    clearN = 1'b1;
    tick(1);
    check("clear level", int'(level), 0);
    check("clear win_OutLow", int'(winN), 1);

    // held-low advance at level 2 gives a single step
    expectPulse(1, 1, 1);
    pulseAdvance();
    expectPulse(2, 1, 1);
    pulseAdvance();
    expectPulse(3, 1, 1);
    advN = 1'b0;
    tick(100);
    advN = 1'b1;
    tick(3);
    check("held advance level", int'(level), 3);

    // clear coincident with an advance edge at level 3
    advN = 1'b0;
    clearN = 1'b0;
    tick(1);
    check("clear+adv level", int'(level), 0);
    check("clear+adv levelup", int'(levelup), 0);
    check("clear+adv win_OutLow", int'(winN), 1);
    clearN = 1'b1;
    tick(5);
    check("after clear, held advance level", int'(level), 0);
    advN = 1'b1;
    tick(2);
    check("after release level", int'(level), 0);

    // asynchronous reset while in WIN
    for (int i = 1; i <= MAXL; i++) begin
      expectPulse(i, (i == MAXL) ? 0 : 1, 1);
      pulseAdvance();
    end
    expectPulse(MAXL, 0, 0);
    advN = 1'b0;
    tick(1);
    advN = 1'b1;
    tick(1);
    check("pre-reset win_OutLow", int'(winN), 0);
    #2;
    rst = 1'b1;
    #1;
    check("async reset level", int'(level), 0);
    check("async reset win_OutLow", int'(winN), 1);
    check("async reset last_OutLow", int'(lastN), 1);
    check("async reset levelup", int'(levelup), 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check("post-reset level", int'(level), 0);
    expectPulse(1, 1, 1);
    pulseAdvance();
    check("post-reset advance level", int'(level), 1);

    tick(2);
    check("scoreboard drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
